// File: rtl/core_pkg.sv
// Shared definitions for the pipeline hazard controller.
package core_pkg;

   // Controller state: normal issue, load-use stall, or waiting on the mul/div unit.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      MDU_WAIT = 2'd2
   } state_t;

   // Architectural zero register; never the source of a hazard.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Initial value of the load-stall down counter.
   // The first stall cycle is spent in RUN, so LD_STALL covers the remaining
   // LOAD_LAT-1 cycles and the counter starts at LOAD_LAT-2.
   function automatic logic [1:0] ld_cnt_init(input int lat);
      if (lat > 1) begin
         return 2'(lat - 2);
      end
      return 2'd0;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance event counting.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   // Count events; hold at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (inc && (r_q != {W{1'b1}})) begin
         r_q <= r_q + W'(1);
      end
   end

   assign q = r_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use stalls,
// EX-resolved redirects (predict-not-taken with flush) and mul/div waits.
// Control outputs are Mealy and reach the pipeline registers with no latency.
//
// Handshake: mdu_start is a one-cycle request issued in RUN when a mul/div
// first reaches EX; mdu_done is a one-cycle completion pulse from the unit,
// accepted only in MDU_WAIT and never on the same cycle as mdu_start.
module hazard_ctrl
   import core_pkg::*;
#(
   parameter int NRS      = 2,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [NRS*5-1:0] id_rs_addr,
   input  logic [NRS-1:0]   id_rs_used,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_reg_write,
   input  logic             ex_is_load,
   input  logic             ex_is_muldiv,
   input  logic             redirect,
   input  logic             mdu_done,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             mdu_start,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output state_t           o_dbg_state,
   output logic [1:0]       o_dbg_ld_cnt
);

   localparam logic [1:0] LD_INIT = ld_cnt_init(LOAD_LAT);

   state_t     r_state;
   logic [1:0] r_ld_cnt;

   // While reset is held, decode as RUN with every input inactive.
   state_t         w_state;
   logic           w_redirect;
   logic           w_muldiv;
   logic           w_done;
   logic           w_id_valid;
   logic [NRS-1:0] w_match;
   logic           w_luh;

   logic w_pc_en;
   logic w_ifid_en;
   logic w_ifid_flush;
   logic w_idex_en;
   logic w_idex_flush;
   logic w_mdu_start;
   logic w_flush_evt;

   assign w_state    = rst_n ? r_state : RUN;
   assign w_redirect = redirect & rst_n;
   assign w_muldiv   = ex_is_muldiv & rst_n;
   assign w_done     = mdu_done & rst_n;
   assign w_id_valid = id_valid & rst_n;

   // One comparator per ID source port; unused ports never match.
   for (genvar k = 0; k < NRS; k++) begin : g_match
      assign w_match[k] = id_rs_used[k] & (id_rs_addr[5*k +: 5] == ex_rd_addr);
   end

   assign w_luh = w_id_valid & ex_is_load & ex_reg_write &
                  (ex_rd_addr != REG_ZERO) & (|w_match);

   // Mealy decode of enables/flushes; priority redirect > mul/div > load-use.
   always_comb begin
      w_pc_en      = 1'b1;
      w_ifid_en    = 1'b1;
      w_ifid_flush = 1'b0;
      w_idex_en    = 1'b1;
      w_idex_flush = 1'b0;
      w_mdu_start  = 1'b0;
      w_flush_evt  = 1'b0;
      case (w_state)
         RUN: begin
            if (w_redirect) begin
               w_ifid_flush = 1'b1;
               w_idex_flush = 1'b1;
               w_flush_evt  = 1'b1;
            end else if (w_muldiv) begin
               w_pc_en     = 1'b0;
               w_ifid_en   = 1'b0;
               w_idex_en   = 1'b0;
               w_mdu_start = 1'b1;
            end else if (w_luh) begin
               w_pc_en      = 1'b0;
               w_ifid_en    = 1'b0;
               w_idex_flush = 1'b1;
            end
         end
         LD_STALL: begin
            // EX holds a bubble here; a redirect is unexpected but still honoured.
            if (w_redirect) begin
               w_ifid_flush = 1'b1;
               w_idex_flush = 1'b1;
               w_flush_evt  = 1'b1;
            end else begin
               w_pc_en      = 1'b0;
               w_ifid_en    = 1'b0;
               w_idex_flush = 1'b1;
            end
         end
         MDU_WAIT: begin
            // Freeze the front end; on done let the mul/div advance with a bubble behind it.
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = w_done;
            w_idex_flush = w_done;
         end
         default: begin
            w_pc_en = 1'b1;
         end
      endcase
   end

   // State and load-stall down counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= RUN;
         r_ld_cnt <= 2'd0;
      end else begin
         case (r_state)
            RUN: begin
               if (redirect) begin
                  r_state <= RUN;
               end else if (ex_is_muldiv) begin
                  r_state <= MDU_WAIT;
               end else if (w_luh && (LOAD_LAT > 1)) begin
                  r_state  <= LD_STALL;
                  r_ld_cnt <= LD_INIT;
               end
            end
            LD_STALL: begin
               if (redirect) begin
                  r_state  <= RUN;
                  r_ld_cnt <= 2'd0;
               end else if (r_ld_cnt == 2'd0) begin
                  r_state <= RUN;
               end else begin
                  r_ld_cnt <= r_ld_cnt - 2'd1;
               end
            end
            MDU_WAIT: begin
               if (mdu_done) begin
                  r_state <= RUN;
               end
            end
            default: begin
               r_state  <= RUN;
               r_ld_cnt <= 2'd0;
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (~w_pc_en),
      .q     (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_flush_evt),
      .q     (flush_cnt)
   );

   assign pc_en        = w_pc_en;
   assign ifid_en      = w_ifid_en;
   assign ifid_flush   = w_ifid_flush;
   assign idex_en      = w_idex_en;
   assign idex_flush   = w_idex_flush;
   assign mdu_start    = w_mdu_start;
   assign o_dbg_state  = r_state;
   assign o_dbg_ld_cnt = r_ld_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (LOAD_LAT 1, LOAD_LAT 3, LOAD_LAT 2 with
// 4-bit counters) driven by directed vectors, checked every cycle against a
// stall-budget model and by hand-computed literal expectations.
module tb_hazard_ctrl;
   import core_pkg::*;

   localparam int ND = 3;

   typedef struct packed {
      logic       rst_n;
      logic       id_valid;
      logic [9:0] rs_addr;
      logic [1:0] rs_used;
      logic [4:0] ex_rd;
      logic       ex_rw;
      logic       ex_load;
      logic       ex_md;
      logic       redirect;
      logic       done;
   } in_t;

   // Bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, mdu_start.
   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic mdu_start;
   } ctl_t;

   typedef struct {
      int stall_left;
      bit mdu_busy;
      int stall_cnt;
      int flush_cnt;
   } mdl_t;

   localparam logic [31:0] C_NORM  = 32'b110100;
   localparam logic [31:0] C_STALL = 32'b000110;
   localparam logic [31:0] C_START = 32'b000001;
   localparam logic [31:0] C_FROZE = 32'b000000;
   localparam logic [31:0] C_DONE  = 32'b000110;
   localparam logic [31:0] C_REDIR = 32'b111110;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   in_t         in_v [ND];
   ctl_t        ctl_v[ND];
   logic [15:0] sc_v [ND];
   logic [15:0] fc_v [ND];
   state_t      st_v [ND];
   logic [1:0]  lc_v [ND];
   mdl_t        mdl  [ND];

   int n_vec = 0;
   int n_bad = 0;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      localparam int LAT = (g == 1) ? 3 : ((g == 2) ? 2 : 1);
      localparam int CW  = (g == 2) ? 4 : 16;
      logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, mdu_start;
      logic [CW-1:0] sc, fc;
      state_t st;
      logic [1:0] lc;

      hazard_ctrl #(.NRS(2), .LOAD_LAT(LAT), .CNT_W(CW)) u_dut (
         .clk          (clk),
         .rst_n        (in_v[g].rst_n),
         .id_valid     (in_v[g].id_valid),
         .id_rs_addr   (in_v[g].rs_addr),
         .id_rs_used   (in_v[g].rs_used),
         .ex_rd_addr   (in_v[g].ex_rd),
         .ex_reg_write (in_v[g].ex_rw),
         .ex_is_load   (in_v[g].ex_load),
         .ex_is_muldiv (in_v[g].ex_md),
         .redirect     (in_v[g].redirect),
         .mdu_done     (in_v[g].done),
         .pc_en        (pc_en),
         .ifid_en      (ifid_en),
         .ifid_flush   (ifid_flush),
         .idex_en      (idex_en),
         .idex_flush   (idex_flush),
         .mdu_start    (mdu_start),
         .stall_cnt    (sc),
         .flush_cnt    (fc),
         .o_dbg_state  (st),
         .o_dbg_ld_cnt (lc)
      );

      assign ctl_v[g] = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, mdu_start};
      assign sc_v[g]  = 16'(sc);
      assign fc_v[g]  = 16'(fc);
      assign st_v[g]  = st;
      assign lc_v[g]  = lc;
   end

   function automatic int lat_of(input int g);
      return (g == 1) ? 3 : ((g == 2) ? 2 : 1);
   endfunction

   function automatic int max_of(input int g);
      return (g == 2) ? 15 : 65535;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Model: a load-use costs LOAD_LAT stall cycles, a mul/div freezes until done,
   // a redirect squashes IF/ID and ID/EX without stalling.
   task automatic model(input in_t i, input int lat, input int cmax, input mdl_t m,
                        output ctl_t c, output mdl_t n);
      bit haz;
      bit stalled;
      bit flushed;
      haz = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (i.rs_used[k] && (i.rs_addr[5*k +: 5] == i.ex_rd)) haz = 1'b1;
      end
      haz = haz && i.id_valid && i.ex_load && i.ex_rw && (i.ex_rd != 5'd0);
      c = ctl_t'(C_NORM[5:0]);
      n = m;
      stalled = 1'b0;
      flushed = 1'b0;
      if (!i.rst_n) begin
         n.stall_left = 0;
         n.mdu_busy   = 1'b0;
         n.stall_cnt  = 0;
         n.flush_cnt  = 0;
      end else if (m.mdu_busy) begin
         c.pc_en = 1'b0; c.ifid_en = 1'b0;
         c.idex_en = i.done; c.idex_flush = i.done;
         stalled = 1'b1;
         if (i.done) n.mdu_busy = 1'b0;
      end else if (i.redirect) begin
         c.ifid_flush = 1'b1; c.idex_flush = 1'b1;
         n.stall_left = 0;
         flushed = 1'b1;
      end else if (m.stall_left > 0) begin
         c.pc_en = 1'b0; c.ifid_en = 1'b0; c.idex_flush = 1'b1;
         n.stall_left = m.stall_left - 1;
         stalled = 1'b1;
      end else if (i.ex_md) begin
         c.pc_en = 1'b0; c.ifid_en = 1'b0; c.idex_en = 1'b0; c.mdu_start = 1'b1;
         n.mdu_busy = 1'b1;
         stalled = 1'b1;
      end else if (haz) begin
         c.pc_en = 1'b0; c.ifid_en = 1'b0; c.idex_flush = 1'b1;
         n.stall_left = lat - 1;
         stalled = 1'b1;
      end
      if (stalled && (n.stall_cnt < cmax)) n.stall_cnt = n.stall_cnt + 1;
      if (flushed && (n.flush_cnt < cmax)) n.flush_cnt = n.flush_cnt + 1;
   endtask

   // Per-cycle compare of every instance against the model, away from the active edge.
   always @(negedge clk) begin
      ctl_t e;
      mdl_t nx;
      for (int g = 0; g < ND; g++) begin
         model(in_v[g], lat_of(g), max_of(g), mdl[g], e, nx);
         chk($sformatf("dut%0d ctl", g), 32'(ctl_v[g]), 32'(e));
         chk($sformatf("dut%0d stall_cnt", g), 32'(sc_v[g]), 32'(mdl[g].stall_cnt));
         chk($sformatf("dut%0d flush_cnt", g), 32'(fc_v[g]), 32'(mdl[g].flush_cnt));
         if (in_v[g].rst_n && in_v[g].redirect && (st_v[g] != RUN)) begin
            n_bad++;
            $display("FAIL dut%0d protocol: redirect in state %0d", g, st_v[g]);
         end
         if (in_v[g].rst_n && in_v[g].done && ctl_v[g].mdu_start) begin
            n_bad++;
            $display("FAIL dut%0d protocol: mdu_done with mdu_start", g);
         end
         mdl[g] = nx;
      end
   end

   function automatic in_t mk(input logic idv, input logic [4:0] rs0, input logic [4:0] rs1,
                              input logic [1:0] used, input logic [4:0] rd, input logic rw,
                              input logic ld, input logic md, input logic rdr, input logic dn);
      in_t v;
      v.rst_n    = 1'b1;
      v.id_valid = idv;
      v.rs_addr  = {rs1, rs0};
      v.rs_used  = used;
      v.ex_rd    = rd;
      v.ex_rw    = rw;
      v.ex_load  = ld;
      v.ex_md    = md;
      v.redirect = rdr;
      v.done     = dn;
      return v;
   endfunction

   // Apply a vector for the cycle following the next rising edge.
   task automatic cyc(input int g, input in_t v);
      @(posedge clk);
      #1;
      in_v[g] = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_t idle, lw_add, lw_bub, rst_v;
      for (int g = 0; g < ND; g++) begin
         in_v[g] = '0;
         mdl[g]  = '{0, 1'b0, 0, 0};
      end
      idle   = mk(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      // lw x5 in EX, add x6,x5,x1 in ID.
      lw_add = mk(1'b1, 5'd5, 5'd1, 2'b11, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // Same ID instruction with a bubble in EX.
      lw_bub = mk(1'b1, 5'd5, 5'd1, 2'b11, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Reset state, observed while reset is still held.
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int g = 0; g < ND; g++) begin
         chk($sformatf("dut%0d reset state", g), 32'(st_v[g]), 32'(RUN));
         chk($sformatf("dut%0d reset ld_cnt", g), 32'(lc_v[g]), 32'd0);
         chk($sformatf("dut%0d reset stall_cnt", g), 32'(sc_v[g]), 32'd0);
         chk($sformatf("dut%0d reset ctl", g), 32'(ctl_v[g]), C_NORM);
      end
      @(posedge clk);
      #1;
      for (int g = 0; g < ND; g++) in_v[g] = idle;

      // LOAD_LAT=1: exactly one stall cycle.
      cyc(0, lw_add);
      @(negedge clk) chk("l1 luh ctl", 32'(ctl_v[0]), C_STALL);
      cyc(0, lw_bub);
      @(negedge clk) chk("l1 after ctl", 32'(ctl_v[0]), C_NORM);
      chk("l1 stall_cnt", 32'(sc_v[0]), 32'd1);

      // x0 destination with x0 reader, and a match only on an unused port.
      cyc(0, mk(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      @(negedge clk) chk("x0 no stall", 32'(ctl_v[0]), C_NORM);
      cyc(0, mk(1'b1, 5'd3, 5'd7, 2'b01, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
      @(negedge clk) chk("unused port no stall", 32'(ctl_v[0]), C_NORM);

      // Redirect on the same cycle as a load-use hazard.
      cyc(0, mk(1'b1, 5'd5, 5'd1, 2'b11, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
      @(negedge clk) chk("redirect over luh", 32'(ctl_v[0]), C_REDIR);
      cyc(0, idle);
      @(negedge clk) chk("redirect flush_cnt", 32'(fc_v[0]), 32'd1);
      chk("redirect no stall", 32'(sc_v[0]), 32'd1);

      // mul/div with done 4 cycles after start.
      cyc(0, mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      @(negedge clk) chk("mdu start", 32'(ctl_v[0]), C_START);
      for (int i = 0; i < 3; i++) begin
         cyc(0, mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
         @(negedge clk) chk("mdu frozen", 32'(ctl_v[0]), C_FROZE);
      end
      cyc(0, mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
      @(negedge clk) chk("mdu done", 32'(ctl_v[0]), C_DONE);
      cyc(0, idle);
      @(negedge clk) chk("mdu back to run", 32'(st_v[0]), 32'(RUN));
      chk("mdu stall_cnt", 32'(sc_v[0]), 32'd6);

      // LOAD_LAT=3: three stall cycles, ld_cnt 1 -> 0 -> RUN.
      cyc(1, lw_add);
      @(negedge clk) chk("l3 cycle1", 32'(ctl_v[1]), C_STALL);
      cyc(1, lw_bub);
      @(negedge clk) chk("l3 cycle2 state", 32'(st_v[1]), 32'(LD_STALL));
      chk("l3 cycle2 ld_cnt", 32'(lc_v[1]), 32'd1);
      chk("l3 cycle2 ctl", 32'(ctl_v[1]), C_STALL);
      cyc(1, lw_bub);
      @(negedge clk) chk("l3 cycle3 ld_cnt", 32'(lc_v[1]), 32'd0);
      chk("l3 cycle3 ctl", 32'(ctl_v[1]), C_STALL);
      cyc(1, lw_bub);
      @(negedge clk) chk("l3 resume state", 32'(st_v[1]), 32'(RUN));
      chk("l3 resume ctl", 32'(ctl_v[1]), C_NORM);
      chk("l3 stall_cnt", 32'(sc_v[1]), 32'd3);
      cyc(1, idle);

      // CNT_W=4: a redirect, a 2-cycle load stall, then 20 mul/div stall cycles.
      cyc(2, mk(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
      cyc(2, lw_add);
      cyc(2, lw_bub);
      @(negedge clk) chk("l2 ld_stall", 32'(st_v[2]), 32'(LD_STALL));
      cyc(2, lw_bub);
      @(negedge clk) chk("l2 stall_cnt", 32'(sc_v[2]), 32'd2);
      cyc(2, mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < 18; i++) begin
         cyc(2, mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      end
      cyc(2, mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
      cyc(2, idle);
      @(negedge clk) chk("c4 saturated", 32'(sc_v[2]), 32'd15);
      chk("c4 flush_cnt", 32'(fc_v[2]), 32'd1);

      // Reset pulse during MDU_WAIT.
      cyc(2, mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      cyc(2, mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      @(negedge clk) chk("c4 in mdu_wait", 32'(st_v[2]), 32'(MDU_WAIT));
      rst_v = mk(1'b1, 5'd2, 5'd3, 2'b11, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      rst_v.rst_n = 1'b0;
      cyc(2, rst_v);
      @(negedge clk) chk("c4 ctl in reset", 32'(ctl_v[2]), C_NORM);
      cyc(2, idle);
      @(negedge clk) chk("c4 post-reset state", 32'(st_v[2]), 32'(RUN));
      chk("c4 post-reset stall_cnt", 32'(sc_v[2]), 32'd0);
      chk("c4 post-reset flush_cnt", 32'(fc_v[2]), 32'd0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
